// File: rtl/fxp_arith_seq_unit.sv
// Sequential unsigned fixed-point unit: ADD/SUB in one cycle, MUL via one shared
// half-width multiplier over four partial products, SQRT by restoring digit recurrence.
//
// state     | meaning
// S_IDLE    | waiting for start; done pulse (if any) is visible here
// S_MUL_PP  | one half-width partial product per cycle, A0B0, A1B0, A0B1, A1B1
// S_MUL_SUM | select/saturate the product window into the staging result
// S_SQRT_IT | one root bit per cycle, MSB first
// S_FINISH  | publish staged result/overflow, raise done, drop busy
module fxp_arith_seq_unit #(
  parameter int WIDTH    = 32,
  parameter int FBITS    = 10,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int HW  = WIDTH / 2;
  localparam int W2  = 2 * WIDTH;
  localparam int NR  = WIDTH + FBITS;
  localparam int NSQ = NR / 2;
  localparam int RW  = NSQ + 2;
  localparam int CW  = $clog2(NSQ) + 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_PP,
    S_MUL_SUM,
    S_SQRT_IT,
    S_FINISH
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [W2-1:0]    r_acc;
  logic [NR-1:0]    r_rad;
  logic [RW-1:0]    r_rem;
  logic [NSQ-1:0]   r_root;
  logic [WIDTH-1:0] r_stage_res;
  logic             r_stage_ovf;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [HW-1:0]    w_a_half;
  logic [HW-1:0]    w_b_half;
  logic [WIDTH-1:0] w_pp;
  logic [W2-1:0]    w_pp_shifted;
  logic             w_mul_ovf;
  logic [WIDTH-1:0] w_mul_res;
  logic [RW+1:0]    w_sq_lhs;
  logic [RW+1:0]    w_sq_rhs;
  logic             w_sq_ge;
  logic [NSQ-1:0]   w_root_nxt;
  logic             w_sat;

  assign w_sat  = (SATURATE != 0);
  assign w_sum  = {1'b0, operand_1} + {1'b0, operand_2};
  assign w_diff = {1'b0, operand_1} - {1'b0, operand_2};

  // r_cnt runs 3..0 through the partial products, so its low bits pick the halves
  assign w_a_half = r_cnt[0] ? r_op_a[HW-1:0] : r_op_a[WIDTH-1:HW];
  assign w_b_half = r_cnt[1] ? r_op_b[HW-1:0] : r_op_b[WIDTH-1:HW];
  assign w_pp     = WIDTH'(w_a_half) * WIDTH'(w_b_half);

  always_comb begin
    w_pp_shifted = W2'(w_pp);
    case (r_cnt[1:0])
      2'd2, 2'd1: w_pp_shifted = W2'(w_pp) << HW;
      2'd0:       w_pp_shifted = W2'(w_pp) << WIDTH;
      default:    ;
    endcase
  end

  assign w_mul_ovf = |(r_acc >> NR);
  assign w_mul_res = WIDTH'(r_acc >> FBITS);

  assign w_sq_lhs   = {r_rem, r_rad[NR-1 -: 2]};
  assign w_sq_rhs   = {2'b00, r_root, 2'b01};
  assign w_sq_ge    = (w_sq_lhs >= w_sq_rhs);
  assign w_root_nxt = {r_root[NSQ-2:0], w_sq_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_acc       <= '0;
      r_rad       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_stage_res <= '0;
      r_stage_ovf <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            case (operation)
              OP_ADD: begin
                r_stage_ovf <= w_sum[WIDTH];
                r_stage_res <= (w_sat && w_sum[WIDTH]) ? '1 : w_sum[WIDTH-1:0];
                r_state     <= S_FINISH;
              end
              OP_SUB: begin
                r_stage_ovf <= w_diff[WIDTH];
                r_stage_res <= (w_sat && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
                r_state     <= S_FINISH;
              end
              OP_MUL: begin
                r_op_a  <= operand_1;
                r_op_b  <= operand_2;
                r_acc   <= '0;
                r_cnt   <= CW'(3);
                r_state <= S_MUL_PP;
              end
              default: begin
                r_rad   <= NR'(operand_1) << FBITS;
                r_rem   <= '0;
                r_root  <= '0;
                r_cnt   <= CW'(NSQ - 1);
                r_state <= S_SQRT_IT;
              end
            endcase
          end
        end
        S_MUL_PP: begin
          r_acc <= r_acc + w_pp_shifted;
          if (r_cnt == '0) r_state <= S_MUL_SUM;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_MUL_SUM: begin
          r_stage_ovf <= w_mul_ovf;
          r_stage_res <= (w_sat && w_mul_ovf) ? '1 : w_mul_res;
          r_state     <= S_FINISH;
        end
        S_SQRT_IT: begin
          r_rem  <= w_sq_ge ? RW'(w_sq_lhs - w_sq_rhs) : w_sq_lhs[RW-1:0];
          r_root <= w_root_nxt;
          r_rad  <= r_rad << 2;
          if (r_cnt == '0) begin
            r_stage_res <= WIDTH'(w_root_nxt);
            r_stage_ovf <= 1'b0;
            r_state     <= S_FINISH;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FINISH: begin
          result   <= r_stage_res;
          overflow <= r_stage_ovf;
          busy     <= 1'b0;
          done     <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_arith_seq_unit.sv
// Directed bench for fxp_arith_seq_unit: wrap (32/10), saturating (32/10) and 16/4 instances.
module tb_fxp_arith_seq_unit;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_SQRT = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  op = '0, op16 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        start_w = 1'b0, start_s = 1'b0, start_n = 1'b0;

  logic [31:0] res_w, res_s;
  logic [15:0] res_n;
  logic        ovf_w, ovf_s, ovf_n, busy_w, busy_s, busy_n, done_w, done_s, done_n;

  fxp_arith_seq_unit #(.WIDTH(32), .FBITS(10), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start_w), .operation(op),
    .operand_1(a32), .operand_2(b32),
    .result(res_w), .overflow(ovf_w), .busy(busy_w), .done(done_w));

  fxp_arith_seq_unit #(.WIDTH(32), .FBITS(10), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .start(start_s), .operation(op),
    .operand_1(a32), .operand_2(b32),
    .result(res_s), .overflow(ovf_s), .busy(busy_s), .done(done_s));

  fxp_arith_seq_unit #(.WIDTH(16), .FBITS(4), .SATURATE(0)) dut_n16 (
    .clk(clk), .reset(reset), .start(start_n), .operation(op16),
    .operand_1(a16), .operand_2(b16),
    .result(res_n), .overflow(ovf_n), .busy(busy_n), .done(done_n));

  int checks = 0;
  int failures = 0;
  int e0 = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Wrapping multiply model: full product, then window and upper-bit overflow
  function automatic logic [32:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                          input int w, input int f);
    logic [63:0] p, win, mask;
    p    = 64'(a) * 64'(b);
    mask = (64'd1 << w) - 64'd1;
    win  = (p >> f) & mask;
    return {((p >> (w + f)) != 64'd0), win[31:0]};
  endfunction

  task automatic get_out(input int sel, output logic [31:0] r, output logic o,
                         output logic b, output logic d);
    case (sel)
      0:       begin r = res_w;          o = ovf_w; b = busy_w; d = done_w; end
      1:       begin r = res_s;          o = ovf_s; b = busy_s; d = done_s; end
      default: begin r = {16'h0, res_n}; o = ovf_n; b = busy_n; d = done_n; end
    endcase
  endtask

  task automatic launch(input int sel, input logic [1:0] opc, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] r;
    logic o, bz, d;
    if (sel == 2) begin op16 = opc; a16 = a[15:0]; b16 = b[15:0]; start_n = 1'b1; end
    else begin
      op = opc; a32 = a; b32 = b;
      if (sel == 0) start_w = 1'b1; else start_s = 1'b1;
    end
    @(posedge clk);
    #1;
    e0 = cyc;
    start_w = 1'b0; start_s = 1'b0; start_n = 1'b0;
    // operands and operation must be ignored after the accept edge
    op = ~opc; op16 = ~opc; a32 = ~a; b32 = ~b; a16 = ~a[15:0]; b16 = ~b[15:0];
    get_out(sel, r, o, bz, d);
    chk("accept_busy", {63'd0, bz}, 64'd1);
  endtask

  task automatic wait_done(input int sel, input int lat, input logic [31:0] er,
                           input logic eo, input string tag);
    logic [31:0] r;
    logic o, bz, d;
    get_out(sel, r, o, bz, d);
    while (!d && (cyc - e0) <= lat + 4) begin
      @(posedge clk);
      #1;
      get_out(sel, r, o, bz, d);
    end
    chk({tag, "_lat"}, 64'(cyc - e0), 64'(lat));
    chk({tag, "_res"}, {32'd0, r}, {32'd0, er});
    chk({tag, "_ovf"}, {63'd0, o}, {63'd0, eo});
    chk({tag, "_busy"}, {63'd0, bz}, 64'd0);
  endtask

  logic [32:0] m;
  int seen;

  initial begin
    #12;
    chk("rst_res", {32'd0, res_w}, 64'd0);
    chk("rst_ovf", {63'd0, ovf_w}, 64'd0);
    chk("rst_busy", {61'd0, busy_w, busy_s, busy_n}, 64'd0);
    chk("rst_done", {61'd0, done_w, done_s, done_n}, 64'd0);
    @(negedge clk) reset = 1'b0;

    // reset in the middle of a multiply
    launch(0, OP_MUL, 32'h600, 32'h900);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, busy_w}, 64'd0);
    chk("midrst_done", {63'd0, done_w}, 64'd0);
    chk("midrst_res", {32'd0, res_w}, 64'd0);
    @(negedge clk) reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done_w) seen++;
    end
    chk("midrst_nodone", 64'(seen), 64'd0);
    launch(0, OP_ADD, 32'h600, 32'h900);
    wait_done(0, 1, 32'hF00, 1'b0, "add_basic");

    // multiply, then back-to-back sqrt started in the done cycle
    launch(0, OP_MUL, 32'h600, 32'h900);
    wait_done(0, 6, 32'hD80, 1'b0, "mul_basic");
    launch(0, OP_SQRT, 32'h1000, 32'h0);
    wait_done(0, 22, 32'h800, 1'b0, "sqrt_4");

    launch(0, OP_SQRT, 32'h800, 32'h0);
    wait_done(0, 22, 32'h5A8, 1'b0, "sqrt_2");
    launch(0, OP_SQRT, 32'h0, 32'h0);
    wait_done(0, 22, 32'h0, 1'b0, "sqrt_0");

    launch(0, OP_MUL, 32'h80000000, 32'h800);
    wait_done(0, 6, 32'h0, 1'b1, "mul_ovf_wrap");
    launch(1, OP_MUL, 32'h80000000, 32'h800);
    wait_done(1, 6, 32'hFFFFFFFF, 1'b1, "mul_ovf_sat");

    m = mul_ref(32'h12345678, 32'h0009ABCD, 32, 10);
    launch(0, OP_MUL, 32'h12345678, 32'h0009ABCD);
    wait_done(0, 6, m[31:0], m[32], "mul_model");
    m = mul_ref(32'h0003FC01, 32'h0000A7F3, 32, 10);
    launch(0, OP_MUL, 32'h0003FC01, 32'h0000A7F3);
    wait_done(0, 6, m[31:0], m[32], "mul_model2");

    launch(0, OP_SUB, 32'h100, 32'h200);
    wait_done(0, 1, 32'hFFFFFF00, 1'b1, "sub_wrap");
    launch(1, OP_SUB, 32'h100, 32'h200);
    wait_done(1, 1, 32'h0, 1'b1, "sub_sat");
    launch(0, OP_SUB, 32'h900, 32'h600);
    wait_done(0, 1, 32'h300, 1'b0, "sub_plain");
    launch(0, OP_ADD, 32'hFFFFFFFF, 32'h1);
    wait_done(0, 1, 32'h0, 1'b1, "add_wrap");
    launch(1, OP_ADD, 32'hFFFFFFFF, 32'h1);
    wait_done(1, 1, 32'hFFFFFFFF, 1'b1, "add_sat");
    launch(1, OP_ADD, 32'h600, 32'h900);
    wait_done(1, 1, 32'hF00, 1'b0, "add_sat_ok");

    // start while busy is ignored; done is a single-cycle pulse
    launch(0, OP_SQRT, 32'h800, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    op = OP_ADD; a32 = 32'h1; b32 = 32'h1; start_w = 1'b1;
    @(posedge clk);
    #1 start_w = 1'b0;
    wait_done(0, 22, 32'h5A8, 1'b0, "busy_ign");
    @(posedge clk);
    #1;
    chk("done_width", {63'd0, done_w}, 64'd0);
    chk("hold_res", {32'd0, res_w}, {32'd0, 32'h5A8});

    // narrow instance
    m = mul_ref(32'h150, 32'h28, 16, 4);
    launch(2, OP_MUL, 32'h150, 32'h28);
    wait_done(2, 6, m[31:0], m[32], "n16_mul");
    m = mul_ref(32'h1000, 32'h100, 16, 4);
    launch(2, OP_MUL, 32'h1000, 32'h100);
    wait_done(2, 6, m[31:0], m[32], "n16_mul_ovf");
    m = mul_ref(32'hBEEF, 32'h7A31, 16, 4);
    launch(2, OP_MUL, 32'hBEEF, 32'h7A31);
    wait_done(2, 6, m[31:0], m[32], "n16_mul_big");
    launch(2, OP_SQRT, 32'h40, 32'h0);
    wait_done(2, 11, 32'h20, 1'b0, "n16_sqrt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fxp_arith_seq_unit.md
Name: fxp_arith_seq_unit

Overview:
Parametrised, handshaked fixed-point arithmetic unit for unsigned Q(WIDTH-FBITS).FBITS operands. It performs add, subtract, multiply and square root.
- Multiply is iterative and reuses one half-width multiplier. Square root is a digit-by-digit restoring iterator.
- An optional saturation mode and an overflow flag are provided.
- The block sits beside the integer execute unit. The core issues start, stalls on busy and retires on done.

Parameters:
WIDTH, 32, operand/result width; must be even, >= 8.
FBITS, 10, fractional bits; 0 <= FBITS < WIDTH; WIDTH+FBITS must be even.
SATURATE, 0, 1 = clamp on overflow/underflow, 0 = wrap modulo 2^WIDTH.

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
operation  input  2  00 ADD, 01 SUB, 10 MUL, 11 SQRT.
operand_1  input  WIDTH  first operand (the only operand for SQRT).
operand_2  input  WIDTH  second operand (ignored for SQRT).
result  output  WIDTH  registered result; held until the next accepted start.
overflow  output  1  registered; valid with result.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle pulse when result/overflow update.

Behaviour:
- Reset (async, active-high): result=0, overflow=0, busy=0, done=0, FSM=IDLE. All internal accumulators cleared. Reset mid-operation aborts it with no done pulse.
- FSM states: IDLE, MUL_PP (4 sub-steps), MUL_SUM, SQRT_IT, FINISH.
- Accept rule: start=1 in IDLE at edge E0 captures operation and operands, and clears done if set. Operand changes after E0 are ignored. start while busy=1 is ignored; it is neither queued nor an error.
- busy=1 from E0 until the edge at which done rises; it is 0 in the cycle done=1. start may be accepted in the done cycle (back-to-back).
- Latency is edges after E0 at which done=1 and result become valid:
  - ADD/SUB: 1.
  - MUL: 6.
  - SQRT: (WIDTH+FBITS)/2 + 1.
- ADD: sum is WIDTH+1 bits; overflow = carry-out.
  - SATURATE=1 and overflow: result = all-ones.
  - Otherwise: result = sum[WIDTH-1:0].
- SUB: overflow = borrow (operand_1 < operand_2).
  - SATURATE=1 and borrow: result = 0.
  - Otherwise: two's-complement wrap.
- MUL:
  - Operands are split into halves A1/A0, B1/B0 (WIDTH/2 each). One (WIDTH/2)x(WIDTH/2) multiplier is used per cycle, in order A0B0, A1B0, A0B1, A1B1.
  - Each partial product is shifted by 0, W/2, W/2, W into a 2*WIDTH accumulator (full width, no truncation of partials).
  - MUL_SUM takes 1 cycle; FINISH takes 1 cycle.
  - result = P[WIDTH+FBITS-1:FBITS], truncated, no rounding.
  - overflow = |P[2*WIDTH-1:WIDTH+FBITS]. With SATURATE=1 and overflow, result = all-ones.
- SQRT:
  - Radicand R = {operand_1, FBITS zeros} (WIDTH+FBITS bits).
  - The restoring algorithm produces one root bit per cycle, MSB first, for (WIDTH+FBITS)/2 iterations.
  - result = floor(sqrt(R)), zero-extended to WIDTH. overflow is always 0.
  - operand_1=0 gives result=0 at normal latency (no early exit).
- Latency is data-independent for all operations.
- operation is sampled only at accept.

Test Plan:
1. Reset mid-op (WIDTH=32, FBITS=10): start MUL, assert reset on cycle 3 -> busy=0, done never pulses, result=0; then ADD 0x600+0x900 -> result 0xF00 at E0+1, overflow=0.
2. MUL 0x600 (1.5) x 0x900 (2.25) -> done exactly at E0+6, result 0xD80 (3.375), overflow=0. Back-to-back SQRT started in the done cycle is accepted.
3. MUL overflow 0x80000000 x 0x800: SATURATE=0 -> result 0x00000000, overflow=1; SATURATE=1 -> 0xFFFFFFFF, overflow=1.
4. SQRT 0x1000 (4.0) -> 0x800 at E0+22; SQRT 0x800 (2.0) -> 0x5A8; SQRT 0 -> 0, done still at E0+22.
5. SUB 0x100-0x200: SATURATE=0 -> 0xFFFFFF00, overflow=1; SATURATE=1 -> 0, overflow=1. ADD 0xFFFFFFFF+1: SATURATE=0 -> 0, overflow=1.
6. Start while busy: pulse start with different operands during SQRT -> ignored, original result delivered; done pulse is exactly one cycle wide. Repeat a MUL case at WIDTH=16, FBITS=4 against the reference model.
